// File: rtl/execute_unit.sv
// EX stage: single-cycle ALU plus a 32-cycle shift-add unsigned multiplier
// that owns the architectural HI/LO registers and stalls the pipeline while busy.
module execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [2:0]  alu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] RD2_in,
    input  logic [4:0]  WN_in,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  MEM_in,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] RD2_out,
    output logic [4:0]  WN_out,
    output logic [1:0]  WB_out,
    output logic [1:0]  MEM_out,
    output logic        stall,
    output logic        mul_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] prod_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        mul_done_q;

    logic        is_multu_s;
    logic        start_s;
    logic [31:0] alu_s;
    logic [32:0] sum_s;
    logic [63:0] prod_d;

    assign is_multu_s = (alu_op == OP_MULTU);
    assign start_s    = (state_q == ST_IDLE) && issue && is_multu_s && !rst;

    // Single-cycle ALU result; MULTU produces no register-file result.
    always_comb begin
        alu_s = 32'd0;
        case (alu_op)
            OP_AND:   alu_s = src_a & src_b;
            OP_OR:    alu_s = src_a | src_b;
            OP_ADD:   alu_s = src_a + src_b;
            OP_SUB:   alu_s = src_a - src_b;
            OP_SLT:   alu_s = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            OP_MFHI:  alu_s = hi_q;
            OP_MFLO:  alu_s = lo_q;
            OP_MULTU: alu_s = 32'd0;
            default:  alu_s = 32'd0;
        endcase
    end

    // One shift-add step: the 33-bit carry becomes the new product MSB.
    always_comb begin
        sum_s = {1'b0, prod_q[63:32]};
        if (mplier_q[0]) begin
            sum_s = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
        end else begin
            sum_s = {1'b0, prod_q[63:32]};
        end
        prod_d = {sum_s, prod_q[31:1]};
    end

    // Multiplier FSM and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mcand_q    <= 32'd0;
            mplier_q   <= 32'd0;
            prod_q     <= 64'd0;
            cnt_q      <= 5'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            mul_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mul_done_q <= 1'b0;
                    if (start_s) begin
                        mcand_q  <= src_a;
                        mplier_q <= src_b;
                        prod_q   <= 64'd0;
                        cnt_q    <= 5'd0;
                        state_q  <= ST_BUSY;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    prod_q   <= prod_d;
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        hi_q       <= prod_d[63:32];
                        lo_q       <= prod_d[31:0];
                        mul_done_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        state_q    <= ST_BUSY;
                    end
                end
                // DONE ignores the still-held MULTU so it cannot retrigger.
                ST_DONE: begin
                    mul_done_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    mul_done_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_out  = alu_s;
    assign zero     = (alu_s == 32'd0);
    assign RD2_out  = RD2_in;
    assign WN_out   = WN_in;
    assign WB_out   = is_multu_s ? 2'b00 : WB_in;
    assign MEM_out  = is_multu_s ? 2'b00 : MEM_in;
    assign stall    = !rst && (start_s || (state_q == ST_BUSY));
    assign mul_done = mul_done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU ops, sideband, MULTU timing, HI/LO and reset abort.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [2:0]  alu_op;
    logic [31:0] src_a, src_b, RD2_in;
    logic [4:0]  WN_in;
    logic [1:0]  WB_in, MEM_in;
    logic [31:0] alu_out, RD2_out, hi, lo;
    logic        zero, stall, mul_done;
    logic [4:0]  WN_out;
    logic [1:0]  WB_out, MEM_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                           OP_MULTU = 3'b011, OP_MFHI = 3'b100, OP_MFLO = 3'b101,
                           OP_SUB = 3'b110, OP_SLT = 3'b111;

    execute_unit dut (
        .clk(clk), .rst(rst), .issue(issue), .alu_op(alu_op),
        .src_a(src_a), .src_b(src_b), .RD2_in(RD2_in), .WN_in(WN_in),
        .WB_in(WB_in), .MEM_in(MEM_in), .alu_out(alu_out), .zero(zero),
        .RD2_out(RD2_out), .WN_out(WN_out), .WB_out(WB_out), .MEM_out(MEM_out),
        .stall(stall), .mul_done(mul_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic do_multu(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stall_cnt = 0;
        int side_bad = 0;
        issue = 1'b1; alu_op = OP_MULTU; src_a = a; src_b = b;
        WB_in = 2'b11; MEM_in = 2'b11;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (WB_out !== 2'b00 || MEM_out !== 2'b00 || alu_out !== 32'd0) side_bad++;
            if (!stall) break;
            if (mul_done) side_bad++;
            stall_cnt++;
            @(negedge clk);
        end
        vec_cnt++;
        if (stall_cnt !== 33) begin
            err_cnt++;
            $display("FAIL %s stall_len: got %0d expected 33", name, stall_cnt);
        end
        vec_cnt++;
        if (side_bad !== 0) begin
            err_cnt++;
            $display("FAIL %s sideband_forced: %0d bad cycles expected 0", name, side_bad);
        end
        vec_cnt++;
        if (mul_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s mul_done: got %b expected 1", name, mul_done);
        end
        vec_cnt++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            err_cnt++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; issue = 1'b1; alu_op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
        RD2_in = 32'd0; WN_in = 5'd0; WB_in = 2'b00; MEM_in = 2'b00;
        @(negedge clk); #1;
        vec_cnt++;
        if (stall !== 1'b0 || mul_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_state: stall=%b done=%b hi=%h lo=%h expected 0", stall, mul_done, hi, lo);
        end
        @(negedge clk);
        issue = 1'b0; alu_op = OP_ADD;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [2:0]  ops  [7] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLT, OP_SUB};
        logic [31:0] as   [7] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd5};
        logic [31:0] bs   [7] = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd1, 32'hFFFFFFFF, 32'd5};
        logic [31:0] exps [7] = '{32'd16, 32'hFFFFFFFE, 32'd1, 32'd15, 32'd1, 32'd0, 32'd0};
        logic        expz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        issue = 1'b1;
        for (int i = 0; i < 7; i++) begin
            alu_op = ops[i]; src_a = as[i]; src_b = bs[i];
            #1;
            vec_cnt++;
            if (alu_out !== exps[i] || zero !== expz[i] || stall !== 1'b0) begin
                err_cnt++;
                $display("FAIL alu_%0d: got %h z=%b st=%b expected %h z=%b st=0",
                         i, alu_out, zero, stall, exps[i], expz[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sideband();
        issue = 1'b1; alu_op = OP_ADD; src_a = 32'd1; src_b = 32'd2;
        RD2_in = 32'hDEADBEEF; WN_in = 5'd17; WB_in = 2'b10; MEM_in = 2'b01;
        #1;
        vec_cnt++;
        if (RD2_out !== 32'hDEADBEEF || WN_out !== 5'd17 || WB_out !== 2'b10 || MEM_out !== 2'b01) begin
            err_cnt++;
            $display("FAIL sideband: got %h %0d %b %b expected deadbeef 17 10 01",
                     RD2_out, WN_out, WB_out, MEM_out);
        end
        @(negedge clk);
    endtask

    task automatic test_no_issue();
        issue = 1'b0; alu_op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (stall !== 1'b0) begin
                err_cnt++;
                $display("FAIL no_issue_stall_%0d: got %b expected 0", i, stall);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            err_cnt++;
            $display("FAIL no_issue_hilo: got %h_%h expected 0_0", hi, lo);
        end
    endtask

    task automatic test_multu_max();
        do_multu("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        issue = 1'b1; alu_op = OP_MFHI; WB_in = 2'b10; #1;
        vec_cnt++;
        if (alu_out !== 32'hFFFFFFFE || stall !== 1'b0 || mul_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL mfhi_after_max: got %h st=%b dn=%b expected fffffffe 0 0", alu_out, stall, mul_done);
        end
        @(negedge clk);
        alu_op = OP_MFLO; #1;
        vec_cnt++;
        if (alu_out !== 32'h00000001 || WB_out !== 2'b10) begin
            err_cnt++;
            $display("FAIL mflo_after_max: got %h wb=%b expected 00000001 10", alu_out, WB_out);
        end
        @(negedge clk);
    endtask

    task automatic test_multu_zero();
        do_multu("zero", 32'd12345, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        issue = 1'b1; alu_op = OP_MFLO; #1;
        vec_cnt++;
        if (alu_out !== 32'd0 || zero !== 1'b1 || stall !== 1'b0) begin
            err_cnt++;
            $display("FAIL mflo_zero: got %h z=%b st=%b expected 0 1 0", alu_out, zero, stall);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_multu("b2b_first", 32'd3, 32'd5, 32'd0, 32'd15);
        @(negedge clk);
        do_multu("b2b_second", 32'd6, 32'd7, 32'd0, 32'd42);
        @(negedge clk);
        issue = 1'b1; alu_op = OP_MFLO; #1;
        vec_cnt++;
        if (alu_out !== 32'd42) begin
            err_cnt++;
            $display("FAIL b2b_mflo: got %0d expected 42", alu_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_multiply();
        int bad = 0;
        issue = 1'b1; alu_op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
        for (int i = 0; i < 10; i++) @(negedge clk);
        rst = 1'b1; #1;
        vec_cnt++;
        if (stall !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_during_rst: got %b expected 0", stall);
        end
        @(negedge clk);
        rst = 1'b0; issue = 1'b0; #1;
        vec_cnt++;
        if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mul_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL after_rst: st=%b hi=%h lo=%h dn=%b expected 0 0 0 0", stall, hi, lo, mul_done);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (mul_done !== 1'b0 || stall !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL abort_quiet: %0d cycles with done/stall expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sideband();
        test_no_issue();
        test_multu_max();
        test_multu_zero();
        test_back_to_back();
        test_reset_mid_multiply();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL use clock clk and reset rst, synchronous, active-high.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- issue  in  1  valid instruction present in EX
- alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULTU, 100 MFHI, 101 MFLO
- src_a  in  32  operand A
- src_b  in  32  operand B (forwarded/immediate-muxed)
- RD2_in  in  32  store data
- WN_in  in  5  write register number
- WB_in  in  2  WB control bits
- MEM_in  in  2  MEM control bits
- alu_out  out  32  result to EX/MEM
- zero  out  1  alu_out == 0
- RD2_out, WN_out, WB_out, MEM_out  out  32/5/2/2  sideband to EX/MEM
- stall  out  1  freeze PC, IF/ID, ID/EX, and EX/MEM enable
- mul_done  out  1  one-cycle pulse at multiply completion
- hi, lo  out  32 each  architectural HI/LO registers

Function
REQ-003 States SHALL be IDLE, BUSY, and DONE, encoded in 2 bits.
REQ-004 Single-cycle ops SHALL be combinational from inputs: AND, OR, ADD/SUB (mod 2^32, overflow ignored), SLT (signed, result 0 or 1), MFHI=hi, MFLO=lo.
REQ-005 RD2_out, WN_out, WB_out, and MEM_out SHALL equal their inputs combinationally, except as stated in REQ-010.
REQ-006 In IDLE, issue=1 with alu_op=MULTU SHALL latch src_a as multiplicand and src_b as multiplier, clear the 64-bit product and the 5-bit counter, and go to BUSY.
REQ-007 BUSY SHALL do one shift-add step per cycle: if multiplier[0]=1, add the multiplicand into product[63:32] with a 33-bit carry; then shift {carry, product} right by 1, shift the multiplier right by 1, and increment the counter.
REQ-008 On the BUSY cycle with counter==31, the block SHALL write hi=product[63:32] and lo=product[31:0] at the clock edge and go to DONE, for exactly 32 BUSY cycles.
REQ-009 stall SHALL be (IDLE & issue & alu_op==MULTU & !rst) | BUSY, so stall is high for exactly 33 consecutive cycles per MULTU.
REQ-010 For MULTU, alu_out SHALL be 0, and WB_out and MEM_out SHALL be forced to 00, in every state (no register write, no memory access).
REQ-011 DONE SHALL assert mul_done=1 and stall=0, SHALL NOT restart on the still-held MULTU, and SHALL return to IDLE next cycle.
REQ-012 In IDLE, a MULTU followed by MFHI/MFLO on the next instruction SHALL read the updated hi/lo with no extra stall.
REQ-013 issue=0 SHALL never start a multiply; non-MULTU ops SHALL never change state, hi, or lo.

Reset
REQ-014 While rst=1, stall SHALL be 0 and no multiply SHALL start.
REQ-015 At the first clock edge with rst=1, the block SHALL set state=IDLE, hi=lo=0, product, counter, and latched operands to 0, and mul_done=0.
REQ-016 Reset during BUSY or DONE SHALL abort the multiply: hi/lo SHALL become 0, and stall SHALL be 0 in the cycle after the reset edge.

Verification
REQ-017 ALU ops: src_a=7, src_b=9 -> ADD=16, SUB=0xFFFFFFFE, AND=1, OR=15; SLT with A=0xFFFFFFFF, B=1 -> 1; SUB 5-5 -> zero=1.
REQ-018 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high for 33 cycles, mul_done pulse on cycle 34, hi=0xFFFFFFFE, lo=0x00000001; WB_out=00 throughout.
REQ-019 MULTU 12345 x 0 -> hi=0, lo=0 after the same 33-cycle stall; then MFLO next cycle -> alu_out=0, zero=1.
REQ-020 Back-to-back: MULTU 3x5, then MULTU 6x7 issued the cycle after DONE -> second stall of 33 cycles, final lo=42.
REQ-021 Reset mid-multiply: rst pulsed on BUSY cycle 10 -> hi=lo=0, stall=0 the next cycle, and no mul_done pulse.
REQ-022 Sideband: RD2_in=0xDEADBEEF, WN_in=17, WB_in=10, MEM_in=01 on ADD -> outputs match the inputs in the same cycle.
